// File: rtl/cond_sequencer_pkg.sv
// Shared constants for the condition sequencer: FSM state encodings,
// program word layout and captured output width.
package cond_sequencer_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_PRIME = 2'd1;
    localparam logic [1:0] ST_RUN   = 2'd2;
    localparam logic [1:0] ST_FIN   = 2'd3;

    localparam int X_BIT = 1;
    localparam int Y_BIT = 0;

    localparam int TW = 9;

endpackage

// File: rtl/cond_seq_mem.sv
// Result register file: one synchronous write port and one registered read port.
// A read of the entry written on the same edge returns the previous contents.
module cond_seq_mem
    import cond_sequencer_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = TW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata <= '0;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/cond_sequencer.sv
// Drives a condition-driven automaton through a stored (x,y) program, one pair
// per clock, and records the automaton's t-outputs for each step.
module cond_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int TW    = cond_sequencer_pkg::TW
) (
    input  logic          clk,
    input  logic          res,
    input  logic          prg_we,
    input  logic [AW-1:0] prg_addr,
    input  logic [1:0]    prg_data,
    input  logic [AW:0]   len,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          fsm_res,
    output logic          fsm_x,
    output logic          fsm_y,
    input  logic [TW-1:0] fsm_t,
    input  logic [AW-1:0] rd_addr,
    output logic [TW-1:0] rd_data
);

    import cond_sequencer_pkg::*;

    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [1:0]    state;
    logic [AW-1:0] idx;
    logic [AW:0]   len_q;
    logic [1:0]    prog [DEPTH];
    logic [1:0]    step;
    logic          in_run;
    logic          last_step;
    logic          cap_we;

    function automatic logic [AW:0] sat_len(input logic [AW:0] l);
        return (l > DEPTH_L) ? DEPTH_L : l;
    endfunction

    assign in_run    = (state == ST_RUN);
    assign last_step = (({1'b0, idx} + 1'b1) == len_q);
    assign cap_we    = in_run && !abort;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state <= ST_IDLE;
            idx   <= '0;
            len_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    idx <= '0;
                    if (start) begin
                        state <= ST_PRIME;
                        len_q <= sat_len(len);
                    end
                end
                ST_PRIME: begin
                    idx <= '0;
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (len_q == '0) begin
                        state <= ST_FIN;
                    end else begin
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (abort) begin
                        state <= ST_IDLE;
                    end else if (last_step) begin
                        state <= ST_FIN;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    idx   <= '0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Program is only writable while idle so a running sequence is never disturbed.
    always_ff @(posedge clk) begin
        if (prg_we && (state == ST_IDLE)) begin
            prog[prg_addr] <= prg_data;
        end
    end

    assign step    = prog[idx];
    assign busy    = (state != ST_IDLE);
    assign done    = (state == ST_FIN);
    assign fsm_res = !in_run;
    assign fsm_x   = in_run && step[X_BIT];
    assign fsm_y   = in_run && step[Y_BIT];

    // t is combinational in the automaton, so the edge that ends RUN step k captures step k.
    cond_seq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .DW    (TW)
    ) u_res_mem (
        .clk   (clk),
        .rst_n (res),
        .we    (cap_we),
        .waddr (idx),
        .wdata (fsm_t),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

endmodule
